// File: rtl/mem_responder_pkg.sv
// Shared constants, types and helpers for the memory responder.
// Optional feature macro used by the design: MMIO_CYCLE_CNT_EN.
package mem_responder_pkg;

    localparam int MEM_WE_BIT = 0;
    localparam int MEM_OE_BIT = 0;
    localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_D,
        SRC_LD,
        SRC_I
    } fault_src_e;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Behavioural 2**ADDR_W x 32 word array: two synchronous read ports,
// one write port.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic              i_re_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    output logic [31:0]       o_data_a,
    input  logic              i_re_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    output logic [31:0]       o_data_b
);

    logic [31:0] r_mem [0:(1<<ADDR_W)-1];
    logic [31:0] r_data_a;
    logic [31:0] r_data_b;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re_a) begin
            r_data_a <= r_mem[i_addr_a];
        end
        if (i_re_b) begin
            r_data_b <= r_mem[i_addr_b];
        end
    end

    assign o_data_a = r_data_a;
    assign o_data_b = r_data_b;

endmodule

// File: rtl/mem_responder.sv
// Fixed 1-cycle memory responder for the core's fetch and data ports.
// Define MMIO_CYCLE_CNT_EN to map a free-running cycle counter at MMIO_ADDR.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_ADDR = MMIO_ADDR_DEFAULT,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_mem_r_addr,
    output logic [31:0] i_mem_r_data,
    input  logic [31:0] d_mem_w_addr,
    input  logic [31:0] d_mem_w_data,
    input  logic [31:0] d_mem_we,
    input  logic [31:0] d_mem_oe,
    output logic [31:0] d_mem_r_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        fault,
    output logic [31:0] fault_addr
);

    logic [ADDR_W-1:0] w_i_idx;
    logic [ADDR_W-1:0] w_d_idx;
    logic [ADDR_W-1:0] w_ld_idx;
    logic              w_d_we;
    logic              w_d_oe;
    logic              w_d_mmio;
    logic              w_st_acc;
    logic              w_ld_xfer;
    logic [31:0]       w_i_arr;
    logic [31:0]       w_d_arr;
    logic [31:0]       w_d_arr_word;
    logic [31:0]       w_d_word;

    logic              r_p_valid;
    logic [ADDR_W-1:0] r_p_idx;
    logic [31:0]       r_p_data;

    logic              r_i_zero;
    logic              r_i_fwd;
    logic [31:0]       r_i_fdata;
    logic              r_d_zero;
    logic              r_d_fwd;
    logic [31:0]       r_d_fdata;

    logic              r_fault;
    logic [31:0]       r_fault_addr;
    logic              w_i_mis;
    logic              w_d_mis;
    logic              w_ld_mis;
    fault_src_e        w_src;
    logic [31:0]       w_src_addr;

    assign w_i_idx  = i_mem_r_addr[ADDR_W+1:2];
    assign w_d_idx  = d_mem_w_addr[ADDR_W+1:2];
    assign w_ld_idx = ld_addr[ADDR_W+1:2];

    assign w_d_we    = d_mem_we[MEM_WE_BIT] & ~rst;
    assign w_d_oe    = d_mem_oe[MEM_OE_BIT] & ~rst;
    assign ld_ready  = ~rst & ~d_mem_we[MEM_WE_BIT];
    assign w_ld_xfer = ld_valid & ld_ready;
    assign w_st_acc  = w_d_we & ~w_d_mmio;

    mem_array #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk      (clk),
        .i_we     (r_p_valid),
        .i_waddr  (r_p_idx),
        .i_wdata  (r_p_data),
        .i_re_a   (1'b1),
        .i_addr_a (w_i_idx),
        .o_data_a (w_i_arr),
        .i_re_b   (w_d_oe),
        .i_addr_b (w_d_idx),
        .o_data_b (w_d_arr)
    );

    // The array drains P at every edge, reset included, so P is the only
    // place a just-accepted write can live for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_valid <= 1'b0;
        end else if (w_st_acc) begin
            r_p_valid <= 1'b1;
            r_p_idx   <= w_d_idx;
            r_p_data  <= d_mem_w_data;
        end else if (w_ld_xfer) begin
            r_p_valid <= 1'b1;
            r_p_idx   <= w_ld_idx;
            r_p_data  <= ld_data;
        end else begin
            r_p_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_zero <= 1'b1;
            r_i_fwd  <= 1'b0;
        end else begin
            r_i_zero  <= 1'b0;
            r_i_fwd   <= r_p_valid && (r_p_idx == w_i_idx);
            r_i_fdata <= r_p_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_zero <= 1'b1;
            r_d_fwd  <= 1'b0;
        end else if (w_d_oe) begin
            r_d_zero  <= 1'b0;
            r_d_fwd   <= r_p_valid && (r_p_idx == w_d_idx);
            r_d_fdata <= r_p_data;
        end
    end

    assign i_mem_r_data = r_i_zero ? 32'd0 : (r_i_fwd ? r_i_fdata : w_i_arr);
    assign w_d_arr_word = r_d_fwd ? r_d_fdata : w_d_arr;
    assign d_mem_r_data = r_d_zero ? 32'd0 : w_d_word;

`ifdef MMIO_CYCLE_CNT_EN
    logic [31:0] r_cnt;
    logic [31:0] r_d_cnt;
    logic        r_d_mmio;

    assign w_d_mmio = (d_mem_w_addr == MMIO_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 32'd0;
            r_d_cnt  <= 32'd0;
            r_d_mmio <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_d_oe) begin
                r_d_mmio <= w_d_mmio;
                r_d_cnt  <= r_cnt;
            end
        end
    end

    assign w_d_word = r_d_mmio ? r_d_cnt : w_d_arr_word;
`else
    logic w_unused_mmio;

    assign w_d_mmio      = 1'b0;
    assign w_d_word      = w_d_arr_word;
    assign w_unused_mmio = ^MMIO_ADDR;
`endif

    assign w_i_mis  = ~rst & misaligned(i_mem_r_addr[1:0]);
    assign w_d_mis  = (w_d_we | w_d_oe) & misaligned(d_mem_w_addr[1:0]);
    assign w_ld_mis = w_ld_xfer & misaligned(ld_addr[1:0]);

    always_comb begin
        w_src = SRC_NONE;
        if (w_d_mis) begin
            w_src = SRC_D;
        end else if (w_ld_mis) begin
            w_src = SRC_LD;
        end else if (w_i_mis) begin
            w_src = SRC_I;
        end
    end

    always_comb begin
        w_src_addr = 32'd0;
        case (w_src)
            SRC_D:   w_src_addr = d_mem_w_addr;
            SRC_LD:  w_src_addr = ld_addr;
            SRC_I:   w_src_addr = i_mem_r_addr;
            default: w_src_addr = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault      <= 1'b0;
            r_fault_addr <= 32'd0;
        end else if (!r_fault && (w_src != SRC_NONE)) begin
            r_fault      <= 1'b1;
            r_fault_addr <= w_src_addr;
        end
    end

    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;

    logic w_unused;
    assign w_unused = ^{d_mem_we[31:1], d_mem_oe[31:1]};

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder; honours MMIO_CYCLE_CNT_EN when defined.
// Reference model: a word array updated at write acceptance, read before update.
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam logic [31:0] MMIO = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_mem_r_addr;
    logic [31:0] i_mem_r_data;
    logic [31:0] d_mem_w_addr;
    logic [31:0] d_mem_w_data;
    logic [31:0] d_mem_we;
    logic [31:0] d_mem_oe;
    logic [31:0] d_mem_r_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        fault;
    logic [31:0] fault_addr;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mem_r_addr (i_mem_r_addr),
        .i_mem_r_data (i_mem_r_data),
        .d_mem_w_addr (d_mem_w_addr),
        .d_mem_w_data (d_mem_w_data),
        .d_mem_we     (d_mem_we),
        .d_mem_oe     (d_mem_oe),
        .d_mem_r_data (d_mem_r_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .fault        (fault),
        .fault_addr   (fault_addr)
    );

    logic [31:0] mem [DEPTH];
    bit          known [DEPTH];
    logic [31:0] exp_d = 32'd0;
    bit          d_known = 1'b0;
    logic        exp_fault = 1'b0;
    logic [31:0] exp_faddr = 32'd0;
    logic [31:0] cnt = 32'd0;
    int          errors = 0;
    int          checks = 0;

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: inputs are already driven; predict, clock, compare.
    task automatic tick();
        logic        we, oe, mis_i, mis_d, mis_l, xfer, mmio, i_ok;
        logic [31:0] exp_i;
        #2;
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, !rst && !d_mem_we[0]});
        we    = d_mem_we[0];
        oe    = d_mem_oe[0];
        xfer  = ld_valid && !we && !rst;
        mmio  = 1'b0;
`ifdef MMIO_CYCLE_CNT_EN
        mmio  = (d_mem_w_addr == MMIO);
`endif
        mis_i = i_mem_r_addr[1:0] != 0;
        mis_d = (we || oe) && d_mem_w_addr[1:0] != 0;
        mis_l = xfer && ld_addr[1:0] != 0;
        if (rst) begin
            exp_i     = 32'd0;
            i_ok      = 1'b1;
            exp_d     = 32'd0;
            d_known   = 1'b1;
            exp_fault = 1'b0;
            exp_faddr = 32'd0;
            cnt       = 32'd0;
        end else begin
            exp_i = mem[widx(i_mem_r_addr)];
            i_ok  = known[widx(i_mem_r_addr)];
            if (oe) begin
                if (mmio) begin
                    exp_d   = cnt;
                    d_known = 1'b1;
                end else begin
                    exp_d   = mem[widx(d_mem_w_addr)];
                    d_known = known[widx(d_mem_w_addr)];
                end
            end
            if (!exp_fault && (mis_d || mis_l || mis_i)) begin
                exp_fault = 1'b1;
                exp_faddr = mis_d ? d_mem_w_addr : (mis_l ? ld_addr : i_mem_r_addr);
            end
            if (we && !mmio) begin
                mem[widx(d_mem_w_addr)]   = d_mem_w_data;
                known[widx(d_mem_w_addr)] = 1'b1;
            end else if (xfer) begin
                mem[widx(ld_addr)]   = ld_data;
                known[widx(ld_addr)] = 1'b1;
            end
            cnt = cnt + 32'd1;
        end
        @(posedge clk);
        #1;
        if (i_ok) chk("i_data", i_mem_r_data, exp_i);
        if (d_known) chk("d_data", d_mem_r_data, exp_d);
        chk("fault", {31'd0, fault}, {31'd0, exp_fault});
        chk("fault_addr", fault_addr, exp_faddr);
    endtask

    task automatic cyc(input logic r, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic w, input logic o, input logic lv,
                       input logic [31:0] la, input logic [31:0] ldd);
        rst          = r;
        i_mem_r_addr = ia;
        d_mem_w_addr = da;
        d_mem_w_data = wd;
        d_mem_we     = {31'h7FFF_FFFF, w};
        d_mem_oe     = {31'h5555_5555, o};
        ld_valid     = lv;
        ld_addr      = la;
        ld_data      = ldd;
        tick();
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a       = $urandom;
        a[11:2] = 10'($urandom_range(0, 15));
        a[1:0]  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        return a;
    endfunction

    initial begin
        logic [31:0] v0, saved, hla, hld;
        logic        hold;
        foreach (known[k]) known[k] = 1'b0;

        // Reset for two cycles: everything zero, loader not ready.
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("rst_i", i_mem_r_data, 32'd0);
        chk("rst_d", d_mem_r_data, 32'd0);

        // Preload every word through the loader, fetching the previous one.
        for (int k = 0; k < DEPTH; k++) begin
            cyc(0, (k == 0) ? 32'd0 : 32'((k - 1) * 4), 0, 0, 0, 0,
                1, 32'(k * 4), $urandom);
        end

        // Loader write followed by a fetch of the same word.
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF);
        cyc(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        chk("fwd_fetch", i_mem_r_data, 32'hDEAD_BEEF);

        // Store with a simultaneous load returns the old word.
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h40, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 32'h40, 32'h1234_5678, 1, 1, 0, 0, 0);
        chk("st_ld_old", d_mem_r_data, 32'd0);
        cyc(0, 0, 32'h40, 0, 0, 1, 0, 0, 0);
        chk("ld_after_st", d_mem_r_data, 32'h1234_5678);

        // Store beats loader; loader holds and transfers next cycle.
        cyc(0, 0, 32'h80, 32'd1, 1, 0, 1, 32'h84, 32'd2);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h84, 32'd2);
        cyc(0, 0, 32'h80, 0, 0, 1, 0, 0, 0);
        chk("arb_store", d_mem_r_data, 32'd1);
        cyc(0, 0, 32'h84, 0, 0, 1, 0, 0, 0);
        chk("arb_loader", d_mem_r_data, 32'd2);

        // Random traffic with aliasing and occasional misalignment.
        hold = 1'b0;
        hla  = 32'd0;
        hld  = 32'd0;
        for (int k = 0; k < 400; k++) begin
            logic w, o, v;
            w = ($urandom_range(0, 2) == 0);
            o = 1'($urandom_range(0, 1));
            if (hold) begin
                v = 1'b1;
            end else begin
                v   = 1'($urandom_range(0, 1));
                hla = rnd_addr();
                hld = $urandom;
            end
            hold = v && w;
            cyc(0, rnd_addr(), rnd_addr(), $urandom, w, o, v, hla, hld);
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Sticky fault captures only the first misaligned address.
        cyc(0, 0, 32'h42, 0, 0, 1, 0, 0, 0);
        chk("fault_set", {31'd0, fault}, 32'd1);
        chk("fault_first", fault_addr, 32'h42);
        cyc(0, 32'h81, 0, 0, 0, 0, 0, 0, 0);
        chk("fault_sticky", fault_addr, 32'h42);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fault_clr", {31'd0, fault}, 32'd0);
        chk("fault_addr_clr", fault_addr, 32'd0);

`ifdef MMIO_CYCLE_CNT_EN
        cyc(0, 0, MMIO, 0, 0, 1, 0, 0, 0);
        v0 = d_mem_r_data;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, MMIO, 0, 0, 1, 0, 0, 0);
        chk("mmio_delta", d_mem_r_data - v0, 32'd2);
        saved = mem[12'h3FC];
        cyc(0, 0, MMIO, 32'hA5A5_A5A5, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 32'hFF0, 0, 0, 0, 0, 0, 0, 0);
        chk("mmio_store_drop", i_mem_r_data, saved);
`else
        v0    = 32'd0;
        saved = mem[12'h3FC];
        cyc(0, 0, MMIO, 0, 0, 1, 0, 0, 0);
        chk("mmio_alias", d_mem_r_data - v0, saved);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
